// File: rtl/split_com_pkg.sv
`default_nettype none
// ============================================================================
// Module      : split_com_pkg
// Description : Shared definitions for the split-completion round-robin
//               arbiter: FSM state encoding, default field widths and the
//               helper that locates one channel's entry in the packed bus.
// Revision    : 1.0 - initial release
// ============================================================================
package split_com_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Default field widths of one completion entry.
    localparam int c_CMD_W_DEFAULT  = 12;
    localparam int c_MASK_W_DEFAULT = 8;

    // LSB position of channel idx inside the packed entry bus.
    function automatic int entry_lsb(input int idx, input int ent_w);
        return idx * ent_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/split_com_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : split_com_rr_pick
// Description : Combinational round-robin pick. Returns the first set request
//               at or above the pointer, wrapping past the top channel.
// Revision    : 1.0 - initial release
// ============================================================================
module split_com_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_grant,
    output logic          o_any
);

    // Scan offsets from the highest down so the smallest offset wins.
    always_comb begin
        int w_idx;
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (i_req[w_idx]) begin
                o_grant = PW'(w_idx);
                o_any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/split_com_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : split_com_rr_arbiter
// Description : Round-robin arbiter that pops one completion entry at a time
//               from NUM_DIMMS source channels, waits RD_LAT cycles for the
//               source data, then presents cmd/mask/src downstream until
//               accepted. Zero-mask entries are discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module split_com_rr_arbiter
    import split_com_pkg::*;
#(
    parameter int NUM_DIMMS = 4,
    parameter int CMD_W     = c_CMD_W_DEFAULT,
    parameter int MASK_W    = c_MASK_W_DEFAULT,
    parameter int RD_LAT    = 1
) (
    input  logic                                clk,
    input  logic                                aresetn,
    input  logic [NUM_DIMMS*(CMD_W+MASK_W)-1:0] complete_split_in,
    input  logic [NUM_DIMMS-1:0]                pending_complete_split,
    output logic [NUM_DIMMS-1:0]                read_complete_split,
    input  logic                                cmd_ready,
    output logic [CMD_W-1:0]                    complete_split_cmd,
    output logic [MASK_W-1:0]                   complete_split_cmd_valid,
    output logic [$clog2(NUM_DIMMS)-1:0]        complete_split_src,
    output logic [15:0]                         drop_count,
    output logic                                busy
);

    localparam int SRC_W = $clog2(NUM_DIMMS);
    localparam int ENT_W = CMD_W + MASK_W;
    localparam int CNT_W = 3;

    state_t             r_state;
    logic [SRC_W-1:0]   r_ptr;
    logic [SRC_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_wcnt;
    logic [CMD_W-1:0]   r_cmd;
    logic [MASK_W-1:0]  r_mask;
    logic [SRC_W-1:0]   r_src;
    logic [15:0]        r_drop;

    logic [SRC_W-1:0]   w_pick;
    logic               w_any;
    logic [SRC_W-1:0]   w_ptr_next;
    logic [ENT_W-1:0]   w_entry;
    logic [CMD_W-1:0]   w_cmd;
    logic [MASK_W-1:0]  w_mask;
    logic [NUM_DIMMS-1:0] w_rd;

    split_com_rr_pick #(
        .N  (NUM_DIMMS),
        .PW (SRC_W)
    ) u_pick (
        .i_req   (pending_complete_split),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // Pointer moves one past the winner, wrapping at the top channel.
    assign w_ptr_next = (w_pick == SRC_W'(NUM_DIMMS - 1)) ? '0 : w_pick + SRC_W'(1);

    // Entry of the granted channel; cmd occupies the MSBs, mask the LSBs.
    assign w_entry = complete_split_in[entry_lsb(int'(r_grant), ENT_W) +: ENT_W];
    assign w_cmd   = w_entry[ENT_W-1 -: CMD_W];
    assign w_mask  = w_entry[MASK_W-1:0];

    // Pop pulse decoded from registered state so reset removes it at once.
    always_comb begin
        w_rd = '0;
        if (r_state == ST_RD) begin
            w_rd[r_grant] = 1'b1;
        end
    end

    // Arbitration FSM: grant, pop, wait for source data, present, retire.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_wcnt  <= '0;
            r_cmd   <= '0;
            r_mask  <= '0;
            r_src   <= '0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_wcnt  <= CNT_W'(RD_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wcnt == '0) begin
                        if (w_mask != '0) begin
                            r_cmd   <= w_cmd;
                            r_mask  <= w_mask;
                            r_src   <= r_grant;
                            r_state <= ST_OUT;
                        end else begin
                            if (r_drop != 16'hFFFF) begin
                                r_drop <= r_drop + 16'd1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (cmd_ready) begin
                        r_mask  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign read_complete_split      = w_rd;
    assign complete_split_cmd       = r_cmd;
    assign complete_split_cmd_valid = r_mask;
    assign complete_split_src       = r_src;
    assign drop_count               = r_drop;
    assign busy                     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_split_com_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_com_rr_arbiter
// Description : Self-checking bench for split_com_rr_arbiter: directed steps
//               plus randomized entry sets checked against a transaction-level
//               round-robin model and a FIFO source model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_com_rr_arbiter;

    localparam int N   = 4;
    localparam int CW  = 12;
    localparam int MW  = 8;
    localparam int EW  = CW + MW;
    localparam int LAT = 1;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [N*EW-1:0] csi;
    logic [N-1:0]    pend;
    logic            cmd_ready;
    logic [N-1:0]    rd;
    logic [CW-1:0]   ocmd;
    logic [MW-1:0]   omask;
    logic [1:0]      osrc;
    logic [15:0]     odrop;
    logic            obusy;

    logic [N*EW-1:0] csi3;
    logic [N-1:0]    pend3;
    logic            rdy3;
    logic [N-1:0]    rd3;
    logic [CW-1:0]   ocmd3;
    logic [MW-1:0]   omask3;
    logic [1:0]      osrc3;
    logic [15:0]     odrop3;
    logic            obusy3;

    always #5 clk = ~clk;

    split_com_rr_arbiter #(.NUM_DIMMS(N), .CMD_W(CW), .MASK_W(MW), .RD_LAT(LAT)) u_dut (
        .clk(clk), .aresetn(aresetn), .complete_split_in(csi),
        .pending_complete_split(pend), .read_complete_split(rd), .cmd_ready(cmd_ready),
        .complete_split_cmd(ocmd), .complete_split_cmd_valid(omask),
        .complete_split_src(osrc), .drop_count(odrop), .busy(obusy)
    );

    split_com_rr_arbiter #(.NUM_DIMMS(N), .CMD_W(CW), .MASK_W(MW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .aresetn(aresetn), .complete_split_in(csi3),
        .pending_complete_split(pend3), .read_complete_split(rd3), .cmd_ready(rdy3),
        .complete_split_cmd(ocmd3), .complete_split_cmd_valid(omask3),
        .complete_split_src(osrc3), .drop_count(odrop3), .busy(obusy3)
    );

    // Source model: per-channel FIFO; a pop delivers its entry LAT cycles later.
    logic [EW-1:0] fifo [N][DEPTH];
    int            head [N];
    int            tail [N];
    logic [EW-1:0] lat_data [N];
    int            lat_cnt [N];
    bit            lat_act [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_ptr  = 0;
    int m_drop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [EW-1:0] e);
        fifo[k][tail[k]] = e;
        tail[k]++;
        pend[k] = 1'b1;
    endtask

    task automatic src_clear();
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
            lat_act[k] = 1'b0;
            lat_cnt[k] = 0;
            lat_data[k] = '0;
        end
        pend = '0;
    endtask

    // One clock: source reacts to the pulse seen before the edge.
    task automatic tick();
        logic [N-1:0] p;
        p = rd;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (p[k]) begin
                if (head[k] < tail[k]) begin
                    lat_data[k] = fifo[k][head[k]];
                    head[k]++;
                end else begin
                    lat_data[k] = EW'($urandom);
                end
                lat_cnt[k] = LAT - 1;
                lat_act[k] = 1'b1;
                csi[k*EW +: EW] = EW'($urandom);
            end
            if (lat_act[k]) begin
                if (lat_cnt[k] == 0) begin
                    csi[k*EW +: EW] = lat_data[k];
                    lat_act[k] = 1'b0;
                end else begin
                    lat_cnt[k]--;
                end
            end
            pend[k] = (head[k] < tail[k]);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cmd_ready = 1'b0;
        src_clear();
        tick();
        tick();
        aresetn = 1'b1;
        m_ptr = 0;
        m_drop = 0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = !obusy && (pend == '0);
        end
        chk("drain_done", done, 1);
    endtask

    // Round-robin rule applied to the queued entries gives the grant order and
    // the presented entries; the cycle loop then compares the DUT against them.
    task automatic run_model(input bit rnd);
        int            gq[$];
        logic [EW-1:0] oq[$];
        int            sq[$];
        int            h[N];
        int            ptr;
        int            g;
        int            last_pulse;
        bit            done;
        logic [EW-1:0] e;
        logic [N-1:0]  oh;
        logic [MW-1:0] pm;
        logic [CW-1:0] pc;
        logic [1:0]    ps;
        logic          pr;
        int            budget;

        for (int k = 0; k < N; k++) h[k] = head[k];
        ptr = m_ptr;
        forever begin
            g = -1;
            for (int off = N - 1; off >= 0; off--) begin
                if (h[(ptr + off) % N] < tail[(ptr + off) % N]) g = (ptr + off) % N;
            end
            if (g < 0) break;
            gq.push_back(g);
            e = fifo[g][h[g]];
            h[g]++;
            if (e[MW-1:0] == '0) m_drop++;
            else begin
                oq.push_back(e);
                sq.push_back(g);
            end
            ptr = (g + 1) % N;
        end
        m_ptr = ptr;

        budget = 40 * gq.size() + 50;
        last_pulse = 0;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pm = omask; pc = ocmd; ps = osrc; pr = cmd_ready;
            tick();
            if (rd != '0) begin
                if (gq.size() == 0) chk("extra_pulse", rd, 0);
                else begin
                    oh = '0;
                    oh[gq.pop_front()] = 1'b1;
                    chk("grant_order", rd, oh);
                end
                last_pulse = cyc;
            end
            if (pm != '0) begin
                if (pr) chk("accept_clear", omask, 0);
                else chk("hold_stable", {ocmd, omask, osrc}, {pc, pm, ps});
            end else if (omask != '0) begin
                if (oq.size() == 0) chk("extra_output", omask, 0);
                else begin
                    e = oq.pop_front();
                    chk("out_entry", {ocmd, omask, osrc}, {e, 2'(sq.pop_front())});
                    chk("out_latency", cyc - last_pulse, 1 + LAT);
                end
            end else begin
                chk("idle_hold", {ocmd, osrc}, {pc, ps});
            end
            done = (gq.size() == 0) && (oq.size() == 0) && !obusy;
        end
        chk("run_done", done, 1);
        chk("drop_count", odrop, 16'(m_drop));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        logic [CW+MW+1:0] snap;
        bit seen;

        aresetn = 1'b1;
        cmd_ready = 1'b0;
        src_clear();
        csi = N*EW'($urandom);
        csi3 = '0;
        pend3 = '0;
        rdy3 = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        // Reset values, asserted asynchronously before any clock edge.
        chk("rst_rd", rd, 0);
        chk("rst_outs", {ocmd, omask, osrc}, 0);
        chk("rst_drop", odrop, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_mask3", omask3, 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        chk("idle_after_rst", {obusy, rd}, 0);

        // Longer source latency: pulse in cycle 1, mask in cycle 5.
        csi3[3*EW +: EW] = {12'h5A3, 8'h81};
        pend3 = 4'b1000;
        rdy3 = 1'b1;
        tick();
        chk("lat3_pulse", rd3, 4'b1000);
        pend3 = '0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("lat3_wait_mask", omask3, 0);
        end
        tick();
        chk("lat3_out_c5", {ocmd3, omask3, osrc3}, {12'h5A3, 8'h81, 2'd3});
        tick();
        chk("lat3_clear", omask3, 0);

        // Single entry on channel 2 with immediate acceptance.
        cmd_ready = 1'b1;
        push(2, {12'hABC, 8'h05});
        chk("c0_idle", obusy, 0);
        tick();
        chk("c1_pulse", rd, 4'b0100);
        chk("c1_busy", obusy, 1);
        tick();
        chk("c2_no_mask", omask, 0);
        tick();
        chk("c3_out", {ocmd, omask, osrc}, {12'hABC, 8'h05, 2'd2});
        tick();
        chk("c4_clear", omask, 0);
        chk("c4_hold", {ocmd, osrc}, {12'hABC, 2'd2});

        // Zero-mask entry on channel 1 is dropped; IDLE two cycles after pulse.
        push(1, {12'h123, 8'h00});
        tick();
        chk("drop_pulse", rd, 4'b0010);
        tick();
        tick();
        chk("drop_count1", odrop, 1);
        chk("drop_no_out", {obusy, omask, ocmd}, {1'b0, 8'h00, 12'hABC});
        cmd_ready = 1'b0;
        push(3, {12'h3C3, 8'h40});
        push(0, {12'h0F0, 8'h11});
        tick();
        chk("drop_next_grant", rd, 4'b1000);

        // Backpressure: outputs hold, no pulses while stalled.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = (omask != '0);
        end
        chk("bp_present", seen, 1);
        snap = {ocmd, omask, osrc};
        chk("bp_entry", snap, {12'h3C3, 8'h40, 2'd3});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_stable", {ocmd, omask, osrc, rd}, {snap, 4'b0000});
        end
        cmd_ready = 1'b1;
        tick();
        chk("bp_release", omask, 0);
        tick();
        chk("wrap_grant0", rd, 4'b0001);
        drain();

        // Reset during RD: pulse drops at once, pointer restarts at channel 0.
        push(2, {12'h222, 8'h02});
        tick();
        chk("rrd_pulse", rd, 4'b0100);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rrd_pulse_gone", rd, 0);
        chk("rrd_outs", {ocmd, omask, osrc, obusy}, 0);
        chk("rrd_drop", odrop, 0);
        src_clear();
        tick();
        aresetn = 1'b1;
        push(0, {12'h00A, 8'h01});
        push(3, {12'h00B, 8'h02});
        tick();
        chk("rrd_first_ch0", rd, 4'b0001);
        drain();

        // All four channels pending steadily: strict rotation.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++)
                push(k, {CW'(16 * r + k + 1), MW'(k + 1)});
        run_model(1'b0);

        // Randomized entry sets with zero masks and random backpressure.
        for (int round = 0; round < 4; round++) begin
            for (int k = 0; k < N; k++) begin
                int len;
                len = $urandom_range(0, 5);
                for (int j = 0; j < len; j++) begin
                    logic [MW-1:0] mk;
                    mk = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom_range(1, 255));
                    push(k, {CW'($urandom), mk});
                end
            end
            run_model(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/split_com_rr_arbiter.md
SPLIT_COM_RR_ARBITER -- requirements
Module: split_com_rr_arbiter

Interface
REQ-001 Parameter NUM_DIMMS, default 4, SHALL set the number of completion source channels (2..16).
REQ-002 Parameter CMD_W, default 12, SHALL set the command field width.
REQ-003 Parameter MASK_W, default 8, SHALL set the per-unit valid-mask width.
REQ-004 Parameter RD_LAT, default 1, SHALL set the cycles from read pulse to source data stable (1..7).
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-006 aresetn  in  1  SHALL be an asynchronous, active-low reset.
REQ-007 complete_split_in  in  NUM_DIMMS*(CMD_W+MASK_W)  SHALL carry one entry per channel; channel k occupies slice k; within an entry, cmd is in the MSBs and mask in the LSBs.
REQ-008 pending_complete_split  in  NUM_DIMMS  SHALL flag that the channel has an entry to read.
REQ-009 read_complete_split  out  NUM_DIMMS  SHALL be a one-cycle pop pulse to the granted channel.
REQ-010 cmd_ready  in  1  SHALL signal that the downstream accepts the presented command.
REQ-011 complete_split_cmd  out  CMD_W  SHALL carry the broadcast command.
REQ-012 complete_split_cmd_valid  out  MASK_W  SHALL carry the destination-unit mask; nonzero means a command is presented.
REQ-013 complete_split_src  out  clog2(NUM_DIMMS)  SHALL carry the index of the channel that supplied the presented command.
REQ-014 drop_count  out  16  SHALL count entries discarded for a zero mask, saturating at 16'hFFFF.
REQ-015 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 FSM states: IDLE, RD, WAIT, OUT; the FSM SHALL return to IDLE after every entry.
REQ-017 IDLE: if any pending bit is set, the FSM SHALL grant the first set bit at or above rr_ptr (wrapping), latch the grant, set rr_ptr to grant+1 mod NUM_DIMMS, and go to RD, all in one cycle.
REQ-018 RD: read_complete_split SHALL be one-hot on the grant for exactly this cycle, decoded from registered state only; the FSM then goes to WAIT with the wait counter at RD_LAT-1.
REQ-019 WAIT: the FSM SHALL hold for RD_LAT cycles; on the last one it SHALL sample the granted slice.
REQ-020 On sampling, a nonzero mask SHALL load cmd, mask and src into the output registers and move to OUT; a zero mask SHALL increment drop_count and return to IDLE with outputs unchanged.
REQ-021 OUT: outputs SHALL be held stable until cmd_ready is sampled high; on that edge the mask SHALL clear to zero and the FSM SHALL go to IDLE.
REQ-022 Latency: with pending sampled in cycle 0, the pulse SHALL occur in cycle 1 and the mask SHALL be visible from cycle 2+RD_LAT.
REQ-023 Throughput: at most one entry SHALL be accepted per 3+RD_LAT cycles; an IDLE cycle SHALL always separate entries.
REQ-024 A pending bit that deasserts after grant SHALL NOT cancel the pulse; the grant is committed.
REQ-025 If only the channel at rr_ptr-1 is pending, it SHALL be granted again (no idle skip).
REQ-026 rr_ptr SHALL wrap from NUM_DIMMS-1 to 0.
REQ-027 complete_split_cmd and complete_split_src SHALL hold their last values when the mask is zero.

Reset
REQ-028 While aresetn is low: state=IDLE, rr_ptr=0, grant=0, wait counter=0, complete_split_cmd=0, complete_split_cmd_valid=0, complete_split_src=0, drop_count=0, read_complete_split=0, busy=0.
REQ-029 A reset asserted in RD SHALL deassert the pulse immediately; the entry is not replayed.
REQ-030 The first IDLE evaluation after reset release SHALL begin at channel 0.

Structure
REQ-031 A shared package split_com_pkg SHALL hold the state encoding, the default CMD_W/MASK_W values and the entry-slice index helper.
REQ-032 The round-robin pick SHALL be a combinational sub-module split_com_rr_pick (inputs: request vector, pointer; outputs: grant index, any).

Verification
REQ-033 NUM_DIMMS=4, RD_LAT=1, ch2 pending, entry {cmd=12'hABC, mask=8'h05}, cmd_ready=1 -> pulse 4'b0100 in cycle 1; cmd=ABC, mask=05, src=2 in cycle 3; mask 0 in cycle 4.
REQ-034 All 4 pending, steady -> grant order 0,1,2,3,0; each channel pops exactly once per round.
REQ-035 ch1 entry mask=0 -> no output presented, drop_count 0->1, next grant considered two cycles after the pulse.
REQ-036 cmd_ready=0 for 10 cycles while in OUT -> outputs stable for those 10 cycles, no further pulses; cmd_ready=1 -> mask clears on the next edge.
REQ-037 RD_LAT=3, ch3 pending -> pulse in cycle 1, mask visible in cycle 5.
REQ-038 aresetn low during RD, then high -> pulse drops asynchronously, all outputs 0, next grant starts from ch0.
